// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared types and defaults for the VGA timing generator.
//   region_e      : per-axis region of the scan (VISIBLE, FRONT, SYNC, BACK)
//   DEF_*         : default 640x480@60 timing, sync polarity and pixel divider
//   total()       : full axis length from its four region lengths
// -----------------------------------------------------------------------------
package vga_timing_pkg;

  typedef enum logic [1:0] {
    VISIBLE = 2'd0,
    FRONT   = 2'd1,
    SYNC    = 2'd2,
    BACK    = 2'd3
  } region_e;

  // 640x480@60 with a 50 MHz system clock divided by two (25 MHz pixels).
  localparam int   DEF_H_VISIBLE = 640;
  localparam int   DEF_H_FRONT   = 16;
  localparam int   DEF_H_SYNC    = 96;
  localparam int   DEF_H_BACK    = 48;
  localparam int   DEF_V_VISIBLE = 480;
  localparam int   DEF_V_FRONT   = 10;
  localparam int   DEF_V_SYNC    = 2;
  localparam int   DEF_V_BACK    = 33;
  localparam logic DEF_SYNC_POL  = 1'b0;
  localparam int   DEF_PIX_DIV   = 2;
  localparam int   DEF_COORD_W   = 10;
  localparam int   DEF_FRAME_W   = 8;

  function automatic int total(input int vis, input int fp, input int sync, input int bp);
    return vis + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
// One scan axis: a position counter 0..TOTAL-1 plus the region FSM
// VISIBLE -> FRONT -> SYNC -> BACK -> VISIBLE that tracks where the count sits.
// Ports:
//   clkIn   in   system clock, rising edge
//   rstIn   in   synchronous active-high reset (count 0, region VISIBLE)
//   advIn   in   advance the position by one this edge
//   count   out  current position (registered)
//   region  out  region of the current position (registered)
//   wrapOut out  high while advIn is set and count is at TOTAL-1, i.e. the
//                advance taking effect this edge wraps the axis to 0
// -----------------------------------------------------------------------------
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int VIS_LEN   = DEF_H_VISIBLE,
  parameter int FRONT_LEN = DEF_H_FRONT,
  parameter int SYNC_LEN  = DEF_H_SYNC,
  parameter int BACK_LEN  = DEF_H_BACK,
  parameter int COORD_W   = DEF_COORD_W
) (
  input  logic               clkIn,
  input  logic               rstIn,
  input  logic               advIn,
  output logic [COORD_W-1:0] count,
  output region_e            region,
  output logic               wrapOut
);

  localparam int TOTAL = total(VIS_LEN, FRONT_LEN, SYNC_LEN, BACK_LEN);

  // Last position of each region; the region changes when the count leaves it.
  localparam logic [COORD_W-1:0] VIS_END   = COORD_W'(VIS_LEN - 1);
  localparam logic [COORD_W-1:0] FRONT_END = COORD_W'(VIS_LEN + FRONT_LEN - 1);
  localparam logic [COORD_W-1:0] SYNC_END  = COORD_W'(VIS_LEN + FRONT_LEN + SYNC_LEN - 1);
  localparam logic [COORD_W-1:0] LAST      = COORD_W'(TOTAL - 1);

  logic [COORD_W-1:0] count_q;
  region_e            region_q;

  assign count   = count_q;
  assign region  = region_q;
  assign wrapOut = advIn && (count_q == LAST);

  // NOTE: state registers use non-blocking assignments so every register in the
  // block samples the pre-edge values of its neighbours.
  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      count_q  <= '0;
      region_q <= VISIBLE;
    end else if (advIn) begin
      count_q <= (count_q == LAST) ? '0 : count_q + 1'b1;
      case (region_q)
        VISIBLE: if (count_q == VIS_END)   region_q <= FRONT;
        FRONT:   if (count_q == FRONT_END) region_q <= SYNC;
        SYNC:    if (count_q == SYNC_END)  region_q <= BACK;
        BACK:    if (count_q == LAST)      region_q <= VISIBLE;
        default:                           region_q <= VISIBLE;
      endcase
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Parametrised video timing generator: pixel prescaler, horizontal and vertical
// axis counters, registered position/visible/sync outputs, per-pixel, per-line
// and per-frame strobes and a completed-frame counter.
// Ports:
//   clkIn         in   system clock, rising edge
//   rstIn         in   synchronous active-high reset, wins over enableIn
//   enableIn      in   run enable; low freezes prescaler, counters and outputs
//   xValue        out  current pixel column
//   yValue        out  current line
//   inVisibleArea out  current pixel lies in the active region
//   HSync, VSync  out  sync pulses at HSYNC_POL / VSYNC_POL active level
//   pixelTick     out  one-cycle strobe: outputs show a new pixel this cycle
//   lineStart     out  pixelTick for x == 0
//   frameStart    out  pixelTick for x == 0 and y == 0
//   frameCount    out  completed-frame count, wraps modulo 2^FRAME_W
// -----------------------------------------------------------------------------
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_VISIBLE = DEF_H_VISIBLE,
  parameter int   H_FRONT   = DEF_H_FRONT,
  parameter int   H_SYNC    = DEF_H_SYNC,
  parameter int   H_BACK    = DEF_H_BACK,
  parameter int   V_VISIBLE = DEF_V_VISIBLE,
  parameter int   V_FRONT   = DEF_V_FRONT,
  parameter int   V_SYNC    = DEF_V_SYNC,
  parameter int   V_BACK    = DEF_V_BACK,
  parameter logic HSYNC_POL = DEF_SYNC_POL,
  parameter logic VSYNC_POL = DEF_SYNC_POL,
  parameter int   PIX_DIV   = DEF_PIX_DIV,
  parameter int   COORD_W   = DEF_COORD_W,
  parameter int   FRAME_W   = DEF_FRAME_W
) (
  input  logic               clkIn,
  input  logic               rstIn,
  input  logic               enableIn,
  output logic [COORD_W-1:0] xValue,
  output logic [COORD_W-1:0] yValue,
  output logic               inVisibleArea,
  output logic               HSync,
  output logic               VSync,
  output logic               pixelTick,
  output logic               lineStart,
  output logic               frameStart,
  output logic [FRAME_W-1:0] frameCount
);

  localparam int H_TOTAL = total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
  localparam int MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;

  localparam int              P_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [P_W-1:0]  P_LAST = P_W'(PIX_DIV - 1);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_lengths
    $error("vga_timing_gen: every porch and sync length must be at least 1");
  end
  if (PIX_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: PIX_DIV must be at least 1");
  end
  if ((64'd1 << COORD_W) < 64'(MAX_TOTAL)) begin : g_bad_coord_w
    $error("vga_timing_gen: COORD_W too narrow for H_TOTAL/V_TOTAL");
  end

  // ---------------------------------------------------------------------------
  // Prescaler
  // ---------------------------------------------------------------------------
  logic [P_W-1:0] p_q;
  logic           tick;

  assign tick = enableIn && (p_q == P_LAST);

  // ---------------------------------------------------------------------------
  // Axis counters
  // The counters hold the pixel that the *next* tick will emit. On a tick the
  // output registers capture that position and the counters step ahead, so the
  // first tick after reset emits (0,0) and every output stays one register deep.
  // ---------------------------------------------------------------------------
  logic [COORD_W-1:0] h_count;
  logic [COORD_W-1:0] v_count;
  region_e            h_region;
  region_e            v_region;
  logic               h_wrap;
  logic               v_wrap;
  logic               v_adv;

  assign v_adv = tick && h_wrap;

  vga_axis_counter #(
    .VIS_LEN   (H_VISIBLE),
    .FRONT_LEN (H_FRONT),
    .SYNC_LEN  (H_SYNC),
    .BACK_LEN  (H_BACK),
    .COORD_W   (COORD_W)
  ) u_h_axis (
    .clkIn   (clkIn),
    .rstIn   (rstIn),
    .advIn   (tick),
    .count   (h_count),
    .region  (h_region),
    .wrapOut (h_wrap)
  );

  vga_axis_counter #(
    .VIS_LEN   (V_VISIBLE),
    .FRONT_LEN (V_FRONT),
    .SYNC_LEN  (V_SYNC),
    .BACK_LEN  (V_BACK),
    .COORD_W   (COORD_W)
  ) u_v_axis (
    .clkIn   (clkIn),
    .rstIn   (rstIn),
    .advIn   (v_adv),
    .count   (v_count),
    .region  (v_region),
    .wrapOut (v_wrap)
  );

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  logic               started_q;
  logic [COORD_W-1:0] x_q;
  logic [COORD_W-1:0] y_q;
  logic               vis_q;
  logic               hsync_q;
  logic               vsync_q;
  logic               pix_tick_q;
  logic               line_start_q;
  logic               frame_start_q;
  logic [FRAME_W-1:0] frame_cnt_q;

  logic at_line_start;
  logic at_frame_start;

  assign at_line_start  = (h_count == '0);
  assign at_frame_start = at_line_start && (v_count == '0);

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      p_q           <= '0;
      started_q     <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      vis_q         <= 1'b0;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      pix_tick_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      // Strobes are rewritten every edge so a disabled or non-ticking edge
      // always clears them.
      pix_tick_q    <= tick;
      line_start_q  <= tick && at_line_start;
      frame_start_q <= tick && at_frame_start;

      if (enableIn) begin
        p_q <= (p_q == P_LAST) ? '0 : p_q + 1'b1;
      end

      if (tick) begin
        started_q <= 1'b1;
        x_q       <= h_count;
        y_q       <= v_count;
        // Only ticks update this register and the first tick also sets
        // started, so the flag already honours the started qualifier.
        vis_q     <= (h_region == VISIBLE) && (v_region == VISIBLE);
        hsync_q   <= (h_region == SYNC) ? HSYNC_POL : ~HSYNC_POL;
        vsync_q   <= (v_region == SYNC) ? VSYNC_POL : ~VSYNC_POL;
        // The first frame after reset is frame 0; later frame starts count up.
        if (at_frame_start && started_q) begin
          frame_cnt_q <= frame_cnt_q + 1'b1;
        end
      end
    end
  end

  assign xValue        = x_q;
  assign yValue        = y_q;
  assign inVisibleArea = vis_q;
  assign HSync         = hsync_q;
  assign VSync         = vsync_q;
  assign pixelTick     = pix_tick_q;
  assign lineStart     = line_start_q;
  assign frameStart    = frame_start_q;
  assign frameCount    = frame_cnt_q;

endmodule
